// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_ADDR_W  : integer register address width
//   X0          : hard-wired zero register address; writes to it are never issued
//   arb_state_e : starvation FSM encoding
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [0:0] {
    StNormal = 1'b0,
    StStall  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order buffer of long-latency results waiting for a free write-port slot.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   push/push_rd/_data   append an entry at the tail
//   pop                  remove the head entry
//   kill_en/kill_rd      drop every entry whose rd matches kill_rd
//   head_rd/head_data    current head entry (zero when empty)
//   count                number of valid entries
// Survivors of pop/kill are compacted toward the head with order preserved; a push in the
// same cycle lands right behind the survivors.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  localparam int unsigned CntW      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CntW-1:0]       count
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [CntW-1:0]       count_q, count_d;
  logic [CntW-1:0]       wr;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_d[i]   = '0;
      data_d[i] = '0;
    end
    wr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CntW'(i) < count_q) && !((i == 0) && pop) &&
          !(kill_en && (rd_q[i] == kill_rd))) begin
        rd_d[wr[IdxW-1:0]]   = rd_q[i];
        data_d[wr[IdxW-1:0]] = data_q[i];
        wr = wr + CntW'(1);
      end
    end
    // The caller only pushes when not full, so a slot is always free here.
    if (push && (wr < CntW'(DEPTH))) begin
      rd_d[wr[IdxW-1:0]]   = push_rd;
      data_d[wr[IdxW-1:0]] = push_data;
      wr = wr + CntW'(1);
    end
    count_d = wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign head_rd   = rd_q[0];
  assign head_data = data_q[0];
  assign count     = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single integer register-file write port between the pipeline WB stage and a
// long-latency unit (LU). Pipeline writes always win; LU results without a free slot wait in an
// in-order buffer, and a WB bubble is requested when the buffer head starves.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   p_we/p_rd/p_data              pipeline WB write
//   lu_valid/lu_ready/lu_rd/lu_data  LU result handshake
//   rf_we/rf_rd/rf_wdata          register-file write port
//   wb_stall_req                  ask pipeline to insert a WB bubble
//   lu_pending                    buffer non-empty
//   occupancy                     valid buffer entries
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned OccW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_we,
  input  logic [REG_ADDR_W-1:0] p_rd,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [DATA_WIDTH-1:0] lu_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_stall_req,
  output logic                  lu_pending,
  output logic [OccW-1:0]       occupancy
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic                  busy;
  logic                  head_valid;
  logic                  head_killed;
  logic                  head_gone;
  logic                  accept;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [OccW-1:0]       count;
  logic [StarveW-1:0]    starve_q, starve_d;
  arb_state_e            state_q, state_d;

  // rd=0 pipeline writes are architecturally no-ops, so the slot counts as free.
  assign busy       = p_we && (p_rd != X0);
  assign head_valid = (count != '0);
  assign lu_ready   = (count < OccW'(DEPTH));
  assign accept     = lu_valid && lu_ready;
  assign bypass     = !busy && !head_valid && lu_valid && (lu_rd != X0);
  assign pop        = !busy && head_valid;
  assign head_killed = busy && head_valid && (head_rd == p_rd);
  assign head_gone  = pop || head_killed;
  // A result for the register the pipeline writes now is older than it, so it is dropped.
  assign push       = accept && (lu_rd != X0) && !bypass && !(busy && (lu_rd == p_rd));

  wb_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (lu_rd),
    .push_data (lu_data),
    .pop       (pop),
    .kill_en   (busy),
    .kill_rd   (p_rd),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (count)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = X0;
    rf_wdata = '0;
    if (busy) begin
      rf_we    = 1'b1;
      rf_rd    = p_rd;
      rf_wdata = p_data;
    end else if (head_valid) begin
      rf_we    = 1'b1;
      rf_rd    = head_rd;
      rf_wdata = head_data;
    end else if (bypass) begin
      rf_we    = 1'b1;
      rf_rd    = lu_rd;
      rf_wdata = lu_data;
    end
  end

  // Counts cycles the head waits; any change of head restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (!head_valid || head_gone) begin
      starve_d = '0;
    end else if (starve_q < StarveW'(STARVE_LIMIT)) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StNormal;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StNormal: if (starve_d == StarveW'(STARVE_LIMIT)) state_d = StStall;
      StStall:  if (head_gone || !head_valid) state_d = StNormal;
      default:  state_d = StNormal;
    endcase
  end

  // FSM outputs.
  always_comb begin
    wb_stall_req = (state_q == StStall);
  end

  assign occupancy  = count;
  assign lu_pending = (count != '0);

endmodule
